// File: rtl/nonce_tx_arb.sv
// nonce_tx_arb
// Round-robin arbiter that pops one nonce at a time from a set of show-ahead
// FIFOs and serialises it into a byte frame for a UART. The frame is an
// optional header byte, the nonce MSB first, and an optional XOR checksum byte.
// All outputs are registered. The rd and transmit pulses appear in the cycle
// after the arbitration or send decision is taken.
module nonce_tx_arb #(
    parameter int NCH     = 2,
    parameter int NONCE_W = 64,
    parameter int HDR_EN  = 0,
    parameter int CSUM_EN = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH-1:0]         avail,
    input  logic [NCH*NONCE_W-1:0] nonce_in,
    output logic [NCH-1:0]         rd,
    input  logic                   tx_idle,
    output logic                   transmit,
    output logic [7:0]             tx_byte,
    input  logic                   flush,
    output logic                   busy,
    output logic [15:0]            frame_cnt
);

    localparam int NB = NONCE_W / 8;
    localparam int FB = NB + HDR_EN + CSUM_EN;
    localparam logic [4:0] LAST_IDX = 5'(FB - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]         state;
    logic [3:0]         rr_ptr;
    logic [4:0]         idx_p0;
    logic [3:0]         chan_p0;
    logic [NONCE_W-1:0] nonce_p0;
    logic [7:0]         csum_p0;

    logic               grant_vld;
    logic [3:0]         grant_ch;
    logic [3:0]         rr_next;
    logic [NCH-1:0]     grant_oh;
    logic [NONCE_W-1:0] grant_nonce;
    logic               is_hdr;
    logic               is_csum;
    logic               last_byte;
    logic [7:0]         cur_byte;
    logic               grant_fire;
    logic               send_fire;

    // Round-robin search: first requesting channel at or after the pointer, else wrap to the lowest.
    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = 4'd0;
        for (int j = 0; j < NCH; j++) begin
            if (!grant_vld && avail[j] && (4'(j) >= rr_ptr)) begin
                grant_vld = 1'b1;
                grant_ch  = 4'(j);
            end
        end
        for (int j = 0; j < NCH; j++) begin
            if (!grant_vld && avail[j]) begin
                grant_vld = 1'b1;
                grant_ch  = 4'(j);
            end
        end
    end

    // Decode the granted channel into a one-hot read strobe and select its nonce slice.
    always_comb begin
        grant_oh    = '0;
        grant_nonce = nonce_in[NONCE_W-1:0];
        for (int j = 0; j < NCH; j++) begin
            if (grant_ch == 4'(j)) begin
                grant_oh[j] = 1'b1;
                grant_nonce = nonce_in[j*NONCE_W +: NONCE_W];
            end
        end
    end

    assign rr_next = (grant_ch == 4'(NCH - 1)) ? 4'd0 : grant_ch + 4'd1;

    // Pick the byte for the current frame position; the nonce byte is always the top of the shifter.
    always_comb begin
        is_hdr    = (HDR_EN != 0) && (idx_p0 == 5'd0);
        is_csum   = (CSUM_EN != 0) && (idx_p0 == LAST_IDX);
        last_byte = (idx_p0 == LAST_IDX);
        if (is_hdr) begin
            cur_byte = {4'h0, chan_p0};
        end else if (is_csum) begin
            cur_byte = csum_p0;
        end else begin
            cur_byte = nonce_p0[NONCE_W-1 -: 8];
        end
    end

    assign grant_fire = (state == IDLE) && grant_vld && !flush;
    assign send_fire  = (state == SEND) && tx_idle && !flush;
    assign busy       = (state != IDLE);

    // Control path: frame FSM, arbitration pointer, output strobes and the frame counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            rr_ptr    <= 4'd0;
            idx_p0    <= 5'd0;
            rd        <= '0;
            transmit  <= 1'b0;
            tx_byte   <= 8'h00;
            frame_cnt <= 16'd0;
        end else begin
            rd       <= '0;
            transmit <= 1'b0;
            if (flush) begin
                // Abort: the byte already handed to the UART finishes on its own.
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (grant_vld) begin
                            state  <= SEND;
                            rd     <= grant_oh;
                            idx_p0 <= 5'd0;
                            rr_ptr <= rr_next;
                        end
                    end
                    SEND: begin
                        if (tx_idle) begin
                            state    <= HOLD;
                            transmit <= 1'b1;
                            tx_byte  <= cur_byte;
                            if (last_byte) begin
                                frame_cnt <= frame_cnt + 16'd1;
                            end
                        end
                    end
                    HOLD: begin
                        // One dead cycle so the UART busy flag has time to drop tx_idle.
                        if (last_byte) begin
                            state <= IDLE;
                        end else begin
                            state  <= SEND;
                            idx_p0 <= idx_p0 + 5'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Data path: captured nonce shifter, channel tag and running checksum.
    always_ff @(posedge clk) begin
        if (grant_fire) begin
            nonce_p0 <= grant_nonce;
            chan_p0  <= grant_ch;
            csum_p0  <= 8'h00;
        end else if (send_fire) begin
            csum_p0 <= csum_p0 ^ cur_byte;
            if (!is_hdr && !is_csum) begin
                nonce_p0 <= nonce_p0 << 8;
            end
        end
    end

endmodule

// File: tb/tb_nonce_tx_arb.sv
// tb_nonce_tx_arb
// Directed bench for nonce_tx_arb. Two instances share the stimulus: u_dut0 with
// plain 8-byte frames and u_dut1 with header and checksum bytes enabled.
module tb_nonce_tx_arb;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   avail;
    logic [127:0] nonce_in;
    logic         tx_idle;
    logic         flush;

    logic [1:0]   d0_rd, d1_rd;
    logic         d0_transmit, d1_transmit;
    logic [7:0]   d0_tx_byte, d1_tx_byte;
    logic         d0_busy, d1_busy;
    logic [15:0]  d0_frame_cnt, d1_frame_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [1:0] rdq0[$];
    logic [1:0] rdq1[$];
    int         tq0[$];

    typedef struct {
        logic [1:0]  avail;
        logic [63:0] n0;
        logic [63:0] n1;
        logic [1:0]  exp_rd;
        logic [63:0] exp_nonce;
        logic [7:0]  exp_hdr;
        logic [7:0]  exp_csum;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vt[4];

    nonce_tx_arb #(.NCH(2), .NONCE_W(64), .HDR_EN(0), .CSUM_EN(0)) u_dut0 (
        .clk(clk), .rst(rst), .avail(avail), .nonce_in(nonce_in), .rd(d0_rd),
        .tx_idle(tx_idle), .transmit(d0_transmit), .tx_byte(d0_tx_byte),
        .flush(flush), .busy(d0_busy), .frame_cnt(d0_frame_cnt)
    );

    nonce_tx_arb #(.NCH(2), .NONCE_W(64), .HDR_EN(1), .CSUM_EN(1)) u_dut1 (
        .clk(clk), .rst(rst), .avail(avail), .nonce_in(nonce_in), .rd(d1_rd),
        .tx_idle(tx_idle), .transmit(d1_transmit), .tx_byte(d1_tx_byte),
        .flush(flush), .busy(d1_busy), .frame_cnt(d1_frame_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Byte / strobe monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (d0_transmit) begin
            q0.push_back(d0_tx_byte);
            tq0.push_back(cyc);
        end
        if (d1_transmit) q1.push_back(d1_tx_byte);
        if (|d0_rd) rdq0.push_back(d0_rd);
        if (|d1_rd) rdq1.push_back(d1_rd);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_q();
        q0.delete(); q1.delete(); rdq0.delete(); rdq1.delete(); tq0.delete();
    endtask

    function automatic logic [63:0] pack(input logic [7:0] q[$], input int off, input int n);
        logic [63:0] v;
        v = 64'h0;
        for (int k = 0; k < n; k++) begin
            v = {v[55:0], ((off + k) < q.size()) ? q[off + k] : 8'h00};
        end
        return v;
    endfunction

    task automatic wait_rd0(input int n, input string name);
        int k;
        k = 0;
        while (rdq0.size() < n && k < 400) begin
            tick();
            k++;
        end
        if (rdq0.size() < n) check(name, 64'(rdq0.size()), 64'(n));
    endtask

    task automatic wait_q0(input int n, input string name);
        int k;
        k = 0;
        while (q0.size() < n && k < 400) begin
            tick();
            k++;
        end
        if (q0.size() < n) check(name, 64'(q0.size()), 64'(n));
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while ((d0_busy || d1_busy) && k < 600) begin
            tick();
            k++;
        end
        if (d0_busy || d1_busy) check(name, {d0_busy, d1_busy}, 64'h0);
    endtask

    initial begin
        logic ok;
        logic seen_tx;

        vt[0] = '{avail: 2'b01, n0: 64'h0123456789ABCDEF, n1: 64'h0, exp_rd: 2'b01,
                  exp_nonce: 64'h0123456789ABCDEF, exp_hdr: 8'h00, exp_csum: 8'h00, exp_cnt: 16'd1};
        vt[1] = '{avail: 2'b10, n0: 64'hFFFFFFFFFFFFFFFF, n1: 64'h0000000000000001, exp_rd: 2'b10,
                  exp_nonce: 64'h0000000000000001, exp_hdr: 8'h01, exp_csum: 8'h00, exp_cnt: 16'd2};
        vt[2] = '{avail: 2'b11, n0: 64'h1122334455667780, n1: 64'h0F0F0F0F0F0F0F0F, exp_rd: 2'b01,
                  exp_nonce: 64'h1122334455667780, exp_hdr: 8'h00, exp_csum: 8'h80, exp_cnt: 16'd3};
        vt[3] = '{avail: 2'b11, n0: 64'h1122334455667780, n1: 64'hDEADBEEF00C0FFEE, exp_rd: 2'b10,
                  exp_nonce: 64'hDEADBEEF00C0FFEE, exp_hdr: 8'h01, exp_csum: 8'hF2, exp_cnt: 16'd4};

        // Reset with requests pending: nothing may move.
        rst = 1'b0; avail = 2'b11; nonce_in = '0; tx_idle = 1'b1; flush = 1'b0;
        tick(); tick();
        check("rst_rd", d0_rd, 2'b00);
        check("rst_transmit", d0_transmit, 1'b0);
        check("rst_tx_byte", d0_tx_byte, 8'h00);
        check("rst_busy", d0_busy, 1'b0);
        check("rst_frame_cnt", d0_frame_cnt, 16'h0);
        avail = 2'b00;
        tick();
        rst = 1'b1;
        tick();

        // Table-driven single frames.
        for (int r = 0; r < 4; r++) begin
            clear_q();
            nonce_in = {vt[r].n1, vt[r].n0};
            avail    = vt[r].avail;
            wait_rd0(1, "vec_rd_timeout");
            avail = 2'b00;
            wait_idle("vec_idle_timeout");
            check($sformatf("vec%0d_rd_count", r), 64'(rdq0.size()), 64'd1);
            check($sformatf("vec%0d_rd0", r), (rdq0.size() > 0) ? rdq0[0] : 2'b00, vt[r].exp_rd);
            check($sformatf("vec%0d_rd1", r), (rdq1.size() > 0) ? rdq1[0] : 2'b00, vt[r].exp_rd);
            check($sformatf("vec%0d_nbytes0", r), 64'(q0.size()), 64'd8);
            check($sformatf("vec%0d_bytes0", r), pack(q0, 0, 8), vt[r].exp_nonce);
            check($sformatf("vec%0d_nbytes1", r), 64'(q1.size()), 64'd10);
            check($sformatf("vec%0d_hdr1", r), pack(q1, 0, 1), 64'(vt[r].exp_hdr));
            check($sformatf("vec%0d_bytes1", r), pack(q1, 1, 8), vt[r].exp_nonce);
            check($sformatf("vec%0d_csum1", r), pack(q1, 9, 1), 64'(vt[r].exp_csum));
            check($sformatf("vec%0d_cnt0", r), d0_frame_cnt, vt[r].exp_cnt);
            check($sformatf("vec%0d_cnt1", r), d1_frame_cnt, vt[r].exp_cnt);
            ok = 1'b1;
            for (int k = 1; k < tq0.size(); k++) if (tq0[k] - tq0[k-1] != 2) ok = 1'b0;
            check($sformatf("vec%0d_spacing", r), ok, 1'b1);
        end

        // UART stalled for 50 cycles in SEND.
        clear_q();
        tx_idle  = 1'b0;
        nonce_in = {64'h0, 64'h8877665544332211};
        avail    = 2'b01;
        wait_rd0(1, "stall_rd_timeout");
        avail = 2'b00;
        check("stall_grant", (rdq0.size() > 0) ? rdq0[0] : 2'b00, 2'b01);
        seen_tx = 1'b0;
        ok      = 1'b1;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (d0_transmit) seen_tx = 1'b1;
            if (d0_tx_byte !== 8'hEE) ok = 1'b0;
        end
        check("stall_no_transmit", seen_tx, 1'b0);
        check("stall_tx_byte_stable", ok, 1'b1);
        check("stall_busy", d0_busy, 1'b1);
        tx_idle = 1'b1;
        tick();
        check("stall_release_transmit", d0_transmit, 1'b1);
        check("stall_release_byte", d0_tx_byte, 8'h88);
        wait_idle("stall_idle_timeout");
        check("stall_bytes", pack(q0, 0, 8), 64'h8877665544332211);
        check("stall_cnt", d0_frame_cnt, 16'd5);

        // Flush after the third byte; avail/nonce changes mid-frame must be ignored.
        clear_q();
        nonce_in = {64'hB1B2B3B4B5B6B7B8, 64'hA1A2A3A4A5A6A7A8};
        avail    = 2'b11;
        wait_rd0(1, "flush_rd_timeout");
        nonce_in = {64'h0, 64'hA1A2A3A4A5A6A7A8};
        wait_q0(3, "flush_byte_timeout");
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", d0_busy, 1'b0);
        check("flush_transmit", d0_transmit, 1'b0);
        check("flush_rd", d0_rd, 2'b00);
        check("flush_cnt", d0_frame_cnt, 16'd5);
        check("flush_nbytes", 64'(q0.size()), 64'd3);
        wait_rd0(2, "flush_next_rd_timeout");
        avail = 2'b00;
        wait_idle("flush_idle_timeout");
        check("flush_grants", {((rdq0.size() > 0) ? rdq0[0] : 2'b00), ((rdq0.size() > 1) ? rdq0[1] : 2'b00)}, 4'b1001);
        check("flush_total_bytes", 64'(q0.size()), 64'd11);
        check("flush_partial", pack(q0, 0, 3), 64'hB1B2B3);
        check("flush_next_frame", pack(q0, 3, 8), 64'hA1A2A3A4A5A6A7A8);
        check("flush_next_cnt", d0_frame_cnt, 16'd6);
        check("flush_hdr1_bytes", pack(q1, 0, 4), 64'h01B1B200);

        // Flush coinciding with an IDLE grant: no read, pointer untouched.
        clear_q();
        avail = 2'b11;
        flush = 1'b1;
        tick();
        check("flush_idle_rd", d0_rd, 2'b00);
        check("flush_idle_busy", d0_busy, 1'b0);
        flush = 1'b0;
        tick();
        check("flush_idle_then_grant", d0_rd, 2'b10);
        avail = 2'b00;
        wait_idle("flush_idle_timeout2");
        check("flush_idle_cnt", d0_frame_cnt, 16'd7);

        // Four back-to-back frames with both channels requesting.
        clear_q();
        nonce_in = {64'h2222222222222222, 64'h1111111111111111};
        avail    = 2'b11;
        wait_rd0(4, "b2b_rd_timeout");
        avail = 2'b00;
        wait_idle("b2b_idle_timeout");
        check("b2b_rd_count", 64'(rdq0.size()), 64'd4);
        check("b2b_order", {((rdq0.size() > 0) ? rdq0[0] : 2'b00), ((rdq0.size() > 1) ? rdq0[1] : 2'b00),
                            ((rdq0.size() > 2) ? rdq0[2] : 2'b00), ((rdq0.size() > 3) ? rdq0[3] : 2'b00)}, 8'h66);
        check("b2b_nbytes", 64'(q0.size()), 64'd32);
        check("b2b_cnt", d0_frame_cnt, 16'd11);
        check("b2b_gap_in_frame", (tq0.size() > 1) ? 64'(tq0[1] - tq0[0]) : 64'd0, 64'd2);
        check("b2b_gap_frames", (tq0.size() > 8) ? 64'(tq0[8] - tq0[7]) : 64'd0, 64'd3);

        // Frame counter wrap from 16'hFFFF.
        force u_dut0.frame_cnt = 16'hFFFF;
        tick();
        release u_dut0.frame_cnt;
        tick();
        clear_q();
        avail = 2'b01;
        wait_rd0(1, "wrap_rd_timeout");
        avail = 2'b00;
        wait_idle("wrap_idle_timeout");
        check("wrap_cnt", d0_frame_cnt, 16'h0000);

        // Reset asserted mid-frame.
        clear_q();
        nonce_in = {64'h3333333333333333, 64'h4444444444444444};
        avail    = 2'b11;
        wait_q0(2, "rstmid_byte_timeout");
        avail = 2'b00;
        #2 rst = 1'b0;
        #1;
        check("rstmid_rd", d0_rd, 2'b00);
        check("rstmid_transmit", d0_transmit, 1'b0);
        check("rstmid_tx_byte", d0_tx_byte, 8'h00);
        check("rstmid_busy", {d0_busy, d1_busy}, 2'b00);
        check("rstmid_cnt", {d0_frame_cnt, d1_frame_cnt}, 32'h0);
        tick(); tick();
        rst = 1'b1;
        for (int k = 0; k < 30; k++) tick();
        check("rstmid_no_more_bytes", 64'(q0.size()), 64'd2);
        check("rstmid_idle", d0_busy, 1'b0);
        clear_q();
        avail = 2'b11;
        wait_rd0(1, "rstmid_rd_timeout");
        avail = 2'b00;
        check("rstmid_ptr_reset", (rdq0.size() > 0) ? rdq0[0] : 2'b00, 2'b01);
        wait_idle("rstmid_idle_timeout");
        check("rstmid_frame", pack(q0, 0, 8), 64'h4444444444444444);
        check("rstmid_cnt_after", d0_frame_cnt, 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/nonce_tx_arb.md
NONCE_TX_ARB -- requirements
Module: nonce_tx_arb

Interface
REQ-001 SHALL have parameter NCH, default 2: number of nonce source channels, range 1..16.
REQ-002 SHALL have parameter NONCE_W, default 64: nonce width in bits; must be a multiple of 8, range 8..128.
REQ-003 SHALL have parameter HDR_EN, default 0: 1 prepends a header byte {4'h0, channel index[3:0]} to each frame.
REQ-004 SHALL have parameter CSUM_EN, default 0: 1 appends a checksum byte, the XOR of all earlier bytes in the frame.
REQ-005 SHALL have port clk, input, 1: the only clock; all state is updated on its rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port avail, input, NCH: avail[i]=1 means show-ahead FIFO i is non-empty.
REQ-008 SHALL have port nonce_in, input, NCH*NONCE_W: channel i data at bits [i*NONCE_W +: NONCE_W], valid while avail[i]=1.
REQ-009 SHALL have port rd, output, NCH: one-cycle read pulse to FIFO i.
REQ-010 SHALL have port tx_idle, input, 1: UART not transmitting.
REQ-011 SHALL have port transmit, output, 1: one-cycle UART start pulse.
REQ-012 SHALL have port tx_byte, output, 8: byte to transmit.
REQ-013 SHALL have port flush, input, 1: synchronous frame abort.
REQ-014 SHALL have port busy, output, 1: high whenever state is not IDLE.
REQ-015 SHALL have port frame_cnt, output, 16: number of completed frames, wrapping.

Function
REQ-016 SHALL define frame length FB = NONCE_W/8 + HDR_EN + CSUM_EN bytes.
REQ-017 SHALL implement the states IDLE, SEND and HOLD.
REQ-018 SHALL, in IDLE when any avail bit is 1, in the same cycle:
- pick grant g round-robin, starting at the channel after the last grant (channel 0 first after reset);
- pulse rd[g] for exactly one cycle;
- capture nonce_in slice g and g into internal registers;
- clear the byte index and the checksum accumulator;
- go to SEND.
REQ-019 SHALL keep all rd bits 0 in every cycle except the IDLE grant cycle, with at most one rd bit high per cycle.
REQ-020 SHALL, in SEND with tx_idle=1, pulse transmit for one cycle with tx_byte set to the current frame byte, update the checksum, and go to HOLD.
REQ-021 SHALL, in SEND with tx_idle=0, stay in SEND with transmit=0.
REQ-022 SHALL spend exactly one cycle in HOLD, ignoring tx_idle, to cover UART busy-flag latency.
REQ-023 SHALL leave HOLD to SEND if bytes remain, otherwise to IDLE.
REQ-024 SHALL emit frame bytes in this order: header (if HDR_EN), nonce most-significant byte first, checksum (if CSUM_EN).
REQ-025 SHALL hold tx_byte stable from the transmit pulse until the next transmit pulse.
REQ-026 SHALL increment frame_cnt (modulo 2^16, 16'hFFFF to 0) in the cycle the last byte of a frame is transmitted.
REQ-027 SHALL give minimum spacing of 2 cycles between transmit pulses, and 3 cycles between the last byte of a frame and the first byte of the next.
REQ-028 SHALL, when flush=1 in any state, go to IDLE next cycle with transmit=0, rd=0 and frame_cnt unchanged.
REQ-029 SHALL let a byte already started continue in the UART after a flush.
REQ-030 SHALL give flush priority over a same-cycle IDLE grant, issuing no rd pulse in that cycle.
REQ-031 SHALL ignore avail changes outside IDLE; the captured nonce is unaffected by them.
REQ-032 SHALL NOT affect the round-robin pointer when a frame is flushed; the pointer advances on the grant itself.

Reset
REQ-033 SHALL, while rst=0, asynchronously force: state IDLE, rd=0, transmit=0, tx_byte=8'h00, busy=0, frame_cnt=0, round-robin pointer to channel 0.
REQ-034 SHALL, when reset is asserted mid-frame, drop the partial frame, with the remaining bytes never sent.

Verification
REQ-035 SHALL pass this case: NCH=2, NONCE_W=64, no header or checksum, avail[0]=1, nonce 64'h0123456789ABCDEF, tx_idle=1 -> rd[0] single pulse, then 8 transmit pulses carrying 01,23,45,67,89,AB,CD,EF 2 cycles apart, and frame_cnt=1.
REQ-036 SHALL pass this case: HDR_EN=1, CSUM_EN=1, channel 1 nonce 64'h0000000000000001 -> bytes 01,00,00,00,00,00,00,00,01,00 (checksum 01 XOR 01 = 00).
REQ-037 SHALL pass this case: both avail bits held high for 4 frames -> grants in order 0,1,0,1 and exactly one rd pulse per frame.
REQ-038 SHALL pass this case: tx_idle held 0 for 50 cycles in SEND -> no transmit and tx_byte stable; transmit fires on the first cycle tx_idle=1.
REQ-039 SHALL pass this case: flush after the 3rd byte -> IDLE next cycle, no further bytes, frame_cnt unchanged, next frame from the other channel.
REQ-040 SHALL pass this case: rst low mid-frame, and separately frame_cnt preset by 65536 frames -> all outputs at reset values, and frame_cnt wraps to 0.
